// File: rtl/pc_ras_unit_pkg.sv
// Shared definitions for the program counter with return-address stack.
// ADDR_W is shared with the ROM and instruction register.
package pc_pkg;

    typedef enum logic [1:0] {
        PC_JMP  = 2'b00,
        PC_BRL  = 2'b01,
        PC_CALL = 2'b10,
        PC_RET  = 2'b11
    } pc_mode_e;

endpackage

// File: rtl/pc_ras_unit_ras_stack.sv
// Circular return-address stack: top-of-stack pointer plus entry count.
// A push when full overwrites the oldest entry; pops on empty leave state unchanged.
module ras_stack #(
    parameter int ADDR_W    = 13,
    parameter int RAS_DEPTH = 4
) (
    input  logic              clk_ctrl,
    input  logic              reset_n,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_data,
    output logic [ADDR_W-1:0] top_data,
    output logic              full,
    output logic              empty,
    output logic              overflow,
    output logic              underflow
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    logic [ADDR_W-1:0] mem [RAS_DEPTH];
    logic [PTR_W-1:0]  tos;
    logic [PTR_W-1:0]  tos_inc;
    logic [CNT_W-1:0]  count;

    assign tos_inc   = tos + 1'b1;
    assign full      = (count == CNT_W'(RAS_DEPTH));
    assign empty     = (count == '0);
    assign overflow  = push & full;
    assign underflow = pop & empty;
    assign top_data  = mem[tos];

    always_ff @(posedge clk_ctrl) begin
        if (!reset_n) begin
            tos   <= '0;
            count <= '0;
        end else if (push) begin
            // Wrapping the pointer onto the oldest slot makes overflow a plain overwrite.
            tos <= tos_inc;
            if (!full)
                count <= count + 1'b1;
        end else if (pop && !empty) begin
            tos   <= tos - 1'b1;
            count <= count - 1'b1;
        end
    end

    // Entry storage is deliberately left out of reset.
    always_ff @(posedge clk_ctrl) begin
        if (reset_n && push)
            mem[tos_inc] <= push_data;
    end

endmodule

// File: rtl/pc_ras_unit.sv
// Parametrised program counter: increment, jump, relative branch, call/return
// through an internal return-address stack, with a sticky RAS error flag.
module pc_ras_unit
    import pc_pkg::*;
#(
    parameter int              ADDR_W    = 13,
    parameter int              OFF_W     = 8,
    parameter int              RAS_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0
) (
    input  logic              clk_ctrl,
    input  logic              reset_n,
    input  logic              inc_pc,
    input  logic              load_pc,
    input  logic [1:0]        pc_mode,
    input  logic [ADDR_W-1:0] addr_ir,
    input  logic [OFF_W-1:0]  off_ir,
    input  logic              clr_err,
    output logic [ADDR_W-1:0] addr_pc,
    output logic              ras_full,
    output logic              ras_empty,
    output logic              ras_err
);

    pc_mode_e          mode;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] off_ext;
    logic [ADDR_W-1:0] pc_next;
    logic [ADDR_W-1:0] top_data;
    logic              push;
    logic              pop;
    logic              overflow;
    logic              underflow;

    assign mode    = pc_mode_e'(pc_mode);
    assign pc_inc  = addr_pc + 1'b1;
    assign off_ext = ADDR_W'($signed(off_ir));

    always_comb begin
        pc_next = addr_pc;
        push    = 1'b0;
        pop     = 1'b0;
        if (inc_pc) begin
            if (!load_pc) begin
                pc_next = pc_inc;
            end else begin
                unique case (mode)
                    PC_JMP:  pc_next = addr_ir;
                    PC_BRL:  pc_next = addr_pc + off_ext;
                    PC_CALL: begin
                        pc_next = addr_ir;
                        push    = 1'b1;
                    end
                    PC_RET: begin
                        pc_next = ras_empty ? pc_inc : top_data;
                        pop     = 1'b1;
                    end
                    default: pc_next = addr_pc;
                endcase
            end
        end
    end

    ras_stack #(
        .ADDR_W   (ADDR_W),
        .RAS_DEPTH(RAS_DEPTH)
    ) u_ras (
        .clk_ctrl (clk_ctrl),
        .reset_n  (reset_n),
        .push     (push),
        .pop      (pop),
        .push_data(pc_inc),
        .top_data (top_data),
        .full     (ras_full),
        .empty    (ras_empty),
        .overflow (overflow),
        .underflow(underflow)
    );

    always_ff @(posedge clk_ctrl) begin
        if (!reset_n) begin
            addr_pc <= RESET_VEC;
            ras_err <= 1'b0;
        end else begin
            addr_pc <= pc_next;
            if (overflow || underflow)
                ras_err <= 1'b1;
            else if (clr_err)
                ras_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pc_ras_unit.sv
// Directed and randomized checks of pc_ras_unit against a queue-based model.
module tb_pc_ras_unit;

    localparam int ADDR_W    = 13;
    localparam int OFF_W     = 8;
    localparam int RAS_DEPTH = 4;
    localparam int PC_MOD    = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] RESET_VEC = '0;

    logic              clk_ctrl = 1'b0;
    logic              reset_n  = 1'b0;
    logic              inc_pc   = 1'b0;
    logic              load_pc  = 1'b0;
    logic [1:0]        pc_mode  = 2'b00;
    logic [ADDR_W-1:0] addr_ir  = '0;
    logic [OFF_W-1:0]  off_ir   = '0;
    logic              clr_err  = 1'b0;
    logic [ADDR_W-1:0] addr_pc;
    logic              ras_full;
    logic              ras_empty;
    logic              ras_err;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int m_pc  = 0;
    int m_q[$];
    bit m_err = 1'b0;

    pc_ras_unit #(
        .ADDR_W   (ADDR_W),
        .OFF_W    (OFF_W),
        .RAS_DEPTH(RAS_DEPTH),
        .RESET_VEC(RESET_VEC)
    ) dut (
        .clk_ctrl (clk_ctrl),
        .reset_n  (reset_n),
        .inc_pc   (inc_pc),
        .load_pc  (load_pc),
        .pc_mode  (pc_mode),
        .addr_ir  (addr_ir),
        .off_ir   (off_ir),
        .clr_err  (clr_err),
        .addr_pc  (addr_pc),
        .ras_full (ras_full),
        .ras_empty(ras_empty),
        .ras_err  (ras_err)
    );

    always #5 clk_ctrl = ~clk_ctrl;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_update(input bit rst, input bit inc, input bit load,
                                input int mode, input int addr, input int off,
                                input bit clr);
        bit set_err;
        set_err = 1'b0;
        if (!rst) begin
            m_pc = int'(RESET_VEC);
            m_q.delete();
            m_err = 1'b0;
            return;
        end
        if (inc) begin
            if (!load) begin
                m_pc = (m_pc + 1) % PC_MOD;
            end else begin
                case (mode)
                    0: m_pc = addr;
                    1: begin
                        // Offset is two's complement OFF_W bits.
                        if (off >= (1 << (OFF_W - 1))) off = off - (1 << OFF_W);
                        m_pc = ((m_pc + off) % PC_MOD + PC_MOD) % PC_MOD;
                    end
                    2: begin
                        if (m_q.size() == RAS_DEPTH) begin
                            void'(m_q.pop_front());
                            set_err = 1'b1;
                        end
                        m_q.push_back((m_pc + 1) % PC_MOD);
                        m_pc = addr;
                    end
                    default: begin
                        if (m_q.size() == 0) begin
                            m_pc = (m_pc + 1) % PC_MOD;
                            set_err = 1'b1;
                        end else begin
                            m_pc = m_q.pop_back();
                        end
                    end
                endcase
            end
        end
        if (set_err) m_err = 1'b1;
        else if (clr) m_err = 1'b0;
    endtask

    task automatic step(input bit rst, input bit inc, input bit load, input int mode,
                        input int addr, input int off, input bit clr);
        reset_n = rst;
        inc_pc  = inc;
        load_pc = load;
        pc_mode = 2'(mode);
        addr_ir = ADDR_W'(addr);
        off_ir  = OFF_W'(off);
        clr_err = clr;
        @(posedge clk_ctrl);
        model_update(rst, inc, load, mode, addr, off, clr);
        #1;
        check("addr_pc",   int'(addr_pc),   m_pc);
        check("ras_full",  int'(ras_full),  int'(m_q.size() == RAS_DEPTH));
        check("ras_empty", int'(ras_empty), int'(m_q.size() == 0));
        check("ras_err",   int'(ras_err),   int'(m_err));
    endtask

    task automatic do_inc();            step(1, 1, 0, 0, 0, 0, 0); endtask
    task automatic do_jmp(input int a); step(1, 1, 1, 0, a, 0, 0); endtask
    task automatic do_brl(input int o); step(1, 1, 1, 1, 0, o, 0); endtask
    task automatic do_call(input int a);step(1, 1, 1, 2, a, 0, 0); endtask
    task automatic do_ret();            step(1, 1, 1, 3, 0, 0, 0); endtask

    initial begin
        // Reset for two cycles, then full wrap of the counter
        step(0, 1, 1, 2, 'h123, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        check("reset_pc", int'(addr_pc), 0);
        for (int i = 0; i < PC_MOD + 1; i++) begin
            do_inc();
            if (i == PC_MOD - 2) check("reach_1fff", int'(addr_pc), 'h1FFF);
            if (i == PC_MOD - 1) check("wrap_zero", int'(addr_pc), 0);
        end
        // Disabled cycles freeze the PC regardless of load/mode
        step(1, 0, 1, 0, 'h0AB, 0, 0);
        step(1, 0, 1, 2, 'h0CD, 0, 0);
        check("frozen_pc", int'(addr_pc), 1);

        // Relative branches
        do_jmp('h0010); do_brl('hF0); check("brl_zero", int'(addr_pc), 'h0000);
        do_jmp('h0005); do_brl('hF0); check("brl_wrap_down", int'(addr_pc), 'h1FF5);
        do_jmp('h1FFE); do_brl('h05); check("brl_wrap_up", int'(addr_pc), 'h0003);

        // Nested call/return
        do_jmp('h0100); do_call('h0200); do_call('h0300);
        do_ret(); check("ret_inner", int'(addr_pc), 'h0201);
        do_ret(); check("ret_outer", int'(addr_pc), 'h0101);
        check("nest_empty", int'(ras_empty), 1);
        check("nest_err",   int'(ras_err), 0);

        // Overflow: five calls into a four-deep stack
        for (int i = 1; i <= 5; i++) begin
            do_jmp(i * 'h10);
            do_call('h0800 + i);
        end
        check("ovf_full", int'(ras_full), 1);
        check("ovf_err",  int'(ras_err), 1);
        do_ret(); check("ovf_ret1", int'(addr_pc), 'h51);
        do_ret(); check("ovf_ret2", int'(addr_pc), 'h41);
        do_ret(); check("ovf_ret3", int'(addr_pc), 'h31);
        do_ret(); check("ovf_ret4", int'(addr_pc), 'h21);

        // Underflow and clear priority
        step(1, 0, 0, 0, 0, 0, 1);
        check("clr_after_ovf", int'(ras_err), 0);
        do_jmp('h0040); do_ret();
        check("unf_pc",  int'(addr_pc), 'h0041);
        check("unf_err", int'(ras_err), 1);
        step(1, 1, 1, 3, 0, 0, 1);
        check("set_beats_clr", int'(ras_err), 1);
        step(1, 0, 0, 0, 0, 0, 1);
        check("clr_alone", int'(ras_err), 0);

        // Reset during a call with three entries stacked
        do_call('h0111); do_call('h0222); do_call('h0333);
        step(0, 1, 1, 2, 'h0AAA, 0, 0);
        check("rst_mid_pc",    int'(addr_pc), int'(RESET_VEC));
        check("rst_mid_empty", int'(ras_empty), 1);
        check("rst_mid_err",   int'(ras_err), 0);
        do_ret();
        check("rst_no_push", int'(addr_pc), int'(RESET_VEC) + 1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 63) != 0), ($urandom_range(0, 7) != 0),
                 ($urandom_range(0, 3) != 0), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, PC_MOD - 1)), int'($urandom_range(0, 255)),
                 ($urandom_range(0, 7) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
